// File: rtl/pipeline_pkg.sv
// Shared types and constants for the ID/EX forwarding stage.
// Optional build macro used by the stage: HAZ_PERF_CNT_EN (hazard/forward counters).
package pipeline_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;

  // Control bundle value loaded into EX when a bubble is inserted.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef enum logic {
    RUN,
    LU_STALL
  } haz_state_t;

  typedef enum logic [1:0] {
    SEL_RF,
    SEL_MEM,
    SEL_WB,
    SEL_ZERO
  } fwd_sel_t;

  // Add a small increment to a 32-bit event counter, pinning at all-ones.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cnt} + {31'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// Source-operand select for one ID operand: x0, MEM result, WB result or
// register file, with MEM taking priority over WB. Purely combinational.
module fwd_operand_mux
  import pipeline_pkg::*;
#(
  parameter int XLEN = pipeline_pkg::XLEN
) (
  input  logic [4:0]      idx,
  input  logic            fwd_mem,
  input  logic            fwd_wb,
  input  logic            mem_reg_write,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data,
  output logic            used_fwd
);

  fwd_sel_t sel;

  // Pick the source; a hazard-unit match only counts if that stage really writes.
  always_comb begin
    sel = SEL_RF;
    if (idx == 5'd0) begin
      sel = SEL_ZERO;
    end else if (fwd_mem && mem_reg_write) begin
      sel = SEL_MEM;
    end else if (fwd_wb && wb_reg_write) begin
      sel = SEL_WB;
    end
  end

  // Steer the chosen source onto the operand.
  always_comb begin
    data = rf_data;
    unique case (sel)
      SEL_ZERO: data = '0;
      SEL_MEM:  data = mem_data;
      SEL_WB:   data = wb_data;
      default:  data = rf_data;
    endcase
  end

  assign used_fwd = (sel == SEL_MEM) || (sel == SEL_WB);

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with operand forwarding and a one-bubble
// load-use interlock.
// Optional build macro: HAZ_PERF_CNT_EN adds perf_stall_cnt / perf_fwd_cnt.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal flow; a load-use hit inserts a bubble and stalls IF/ID
//   LU_STALL | bubble is in EX, load now in MEM; capture with MEM forward
module id_ex_forward_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN   = pipeline_pkg::XLEN,
  parameter int CTRL_W = pipeline_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              fwd_mem_rs1,
  input  logic              fwd_mem_rs2,
  input  logic              fwd_wb_rs1,
  input  logic              fwd_wb_rs2,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic [XLEN-1:0]   wb_fwd_data,
  input  logic              hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_op_a,
  output logic [XLEN-1:0]   ex_op_b,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic              stall_if_id
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt
`endif
);

  haz_state_t      state_q, state_d;
  logic            lu;
  logic            load_ex;
  logic            bubble_ex;
  logic            lu_bubble;
  logic [XLEN-1:0] op_a_sel, op_b_sel;
  logic            used_a, used_b;

  fwd_operand_mux #(.XLEN(XLEN)) u_mux_a (
    .idx           (id_rs1),
    .fwd_mem       (fwd_mem_rs1),
    .fwd_wb        (fwd_wb_rs1),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .rf_data       (id_rs1_data),
    .mem_data      (mem_fwd_data),
    .wb_data       (wb_fwd_data),
    .data          (op_a_sel),
    .used_fwd      (used_a)
  );

  fwd_operand_mux #(.XLEN(XLEN)) u_mux_b (
    .idx           (id_rs2),
    .fwd_mem       (fwd_mem_rs2),
    .fwd_wb        (fwd_wb_rs2),
    .mem_reg_write (mem_reg_write),
    .wb_reg_write  (wb_reg_write),
    .rf_data       (id_rs2_data),
    .mem_data      (mem_fwd_data),
    .wb_data       (wb_fwd_data),
    .data          (op_b_sel),
    .used_fwd      (used_b)
  );

  // A load sitting in EX whose destination is read by the ID instruction.
  always_comb begin
    lu = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Next state and stage actions, priority reset > flush > hold > load-use > capture.
  always_comb begin
    state_d     = state_q;
    stall_if_id = 1'b0;
    load_ex     = 1'b0;
    bubble_ex   = 1'b0;
    lu_bubble   = 1'b0;
    if (reset) begin
      state_d = RUN;
    end else if (flush) begin
      bubble_ex = 1'b1;
      state_d   = RUN;
    end else if (hold) begin
      stall_if_id = 1'b1;
    end else if ((state_q == RUN) && lu) begin
      stall_if_id = 1'b1;
      bubble_ex   = 1'b1;
      lu_bubble   = 1'b1;
      state_d     = LU_STALL;
    end else begin
      load_ex = 1'b1;
      state_d = RUN;
    end
  end

  // FSM state and EX pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bubble_ex) begin
        ex_valid     <= 1'b0;
        ex_rd        <= '0;
        ex_op_a      <= '0;
        ex_op_b      <= '0;
        ex_imm       <= '0;
        ex_ctrl      <= CTRL_W'(CTRL_BUBBLE);
        ex_mem_read  <= 1'b0;
        ex_reg_write <= 1'b0;
      end else if (load_ex) begin
        ex_valid     <= id_valid;
        ex_rd        <= id_rd;
        ex_op_a      <= op_a_sel;
        ex_op_b      <= op_b_sel;
        ex_imm       <= id_imm;
        ex_ctrl      <= id_ctrl;
        ex_mem_read  <= id_mem_read;
        ex_reg_write <= id_reg_write;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating counts of load-use bubbles and forwarded operands actually captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (lu_bubble) begin
        perf_stall_cnt <= sat_add(perf_stall_cnt, 2'd1);
      end
      if (load_ex && id_valid) begin
        perf_fwd_cnt <= sat_add(perf_fwd_cnt, {1'b0, used_a} + {1'b0, used_b});
      end
    end
  end
`else
  // Forward-used flags only feed the counters; keep them referenced here.
  logic fwd_used_unused;
  assign fwd_used_unused = used_a | used_b | lu_bubble;
`endif

endmodule
